// File: rtl/gray_pkg.sv
// Shared constants and types for the two-requester gray-code converter.
package gray_pkg;

    localparam int GRAY_WIDTH_DEF = 4;

    typedef enum logic {
        MODE_B2G = 1'b0,
        MODE_G2B = 1'b1
    } mode_e;

    typedef logic req_id_t;

endpackage

// File: rtl/gray_conv.sv
// Combinational binary<->gray converter; gray->binary exists only when
// GRAY_CONV_ARB_G2B_EN is defined, otherwise every operand is binary->gray.
module gray_conv
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] data,
    input  logic             mode,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] b2g_s;
`ifdef GRAY_CONV_ARB_G2B_EN
    logic [WIDTH-1:0] g2b_s;
`else
    logic             unused_mode_s;
    assign unused_mode_s = mode;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == WIDTH - 1) begin : g_msb
            assign b2g_s[i] = data[i];
        end else begin : g_low
            assign b2g_s[i] = data[i+1] ^ data[i];
        end
`ifdef GRAY_CONV_ARB_G2B_EN
        // Each binary bit is the parity of all gray bits at or above it.
        assign g2b_s[i] = ^data[WIDTH-1:i];
`endif
    end

    // Result select between the two conversion directions.
    always_comb begin
        result = b2g_s;
`ifdef GRAY_CONV_ARB_G2B_EN
        if (mode == MODE_G2B) begin
            result = g2b_s;
        end else begin
            result = b2g_s;
        end
`endif
    end

endmodule

// File: rtl/gray_conv_arb.sv
// Round-robin arbiter sharing one gray converter between two requesters,
// with a single registered output slot and a handshake counter.
// Optional gray->binary support: GRAY_CONV_ARB_G2B_EN.
module gray_conv_arb
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic [CNT_W-1:0] conv_cnt
);

    logic             rr_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    req_id_t          out_id_r;
    logic [CNT_W-1:0] conv_cnt_r;

    logic             slot_free_s;
    logic             grant0_s;
    logic             grant1_s;
    logic [WIDTH-1:0] sel_data_s;
    logic             sel_mode_s;
    logic [WIDTH-1:0] conv_result_s;

    // Grant decision; readies are forced low while reset is held.
    always_comb begin
        slot_free_s = !out_valid_r || out_ready;
        grant0_s    = 1'b0;
        grant1_s    = 1'b0;
        if (!rst && slot_free_s) begin
            grant0_s = req0_valid && (!req1_valid || (rr_r == 1'b0));
            grant1_s = req1_valid && (!req0_valid || (rr_r == 1'b1));
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Operand mux feeding the shared converter.
    always_comb begin
        if (grant1_s) begin
            sel_data_s = req1_data;
            sel_mode_s = req1_mode;
        end else begin
            sel_data_s = req0_data;
            sel_mode_s = req0_mode;
        end
    end

    gray_conv #(.WIDTH(WIDTH)) u_conv (
        .data   (sel_data_s),
        .mode   (sel_mode_s),
        .result (conv_result_s)
    );

    // Output slot, round-robin pointer and handshake counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_r        <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_id_r    <= 1'b0;
            conv_cnt_r  <= '0;
        end else begin
            if (out_valid_r && out_ready) begin
                conv_cnt_r <= conv_cnt_r + CNT_W'(1);
            end
            if (grant0_s || grant1_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= conv_result_s;
                out_id_r    <= grant1_s;
                rr_r        <= !grant1_s;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_id     = out_id_r;
    assign conv_cnt   = conv_cnt_r;

endmodule

// File: tb/tb_gray_conv_arb.sv
// Directed self-checking bench for gray_conv_arb (WIDTH=4, CNT_W=8).
module tb_gray_conv_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_mode;
    logic [3:0] req0_data;
    logic       req1_valid, req1_ready, req1_mode;
    logic [3:0] req1_data;
    logic       out_valid, out_ready, out_id;
    logic [3:0] out_data;
    logic [7:0] conv_cnt;

    int tests = 0;
    int fails = 0;

    gray_conv_arb #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_data(req0_data), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_data(req1_data), .req1_mode(req1_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .conv_cnt(conv_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] m_b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] m_g2b(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_s;
        rst = 1'b1; out_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 4'd0; req0_mode = 1'b0;
        req1_valid = 1'b1; req1_data = 4'd0; req1_mode = 1'b0;
        step; step;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_id", 32'(out_id), 32'd0);
        chk("rst_cnt", 32'(conv_cnt), 32'd0);

        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
        step;
        chk("idle_valid", 32'(out_valid), 32'd0);

        // Single request from requester 0
        req0_valid = 1'b1; req0_data = 4'b0101; req0_mode = 1'b0;
        #1;
        chk("t1_ready0", 32'(req0_ready), 32'd1);
        chk("t1_ready1", 32'(req1_ready), 32'd0);
        step;
        req0_valid = 1'b0;
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'b0111);
        chk("t1_id", 32'(out_id), 32'd0);
        chk("t1_cnt0", 32'(conv_cnt), 32'd0);
        step;
        chk("t1_cnt1", 32'(conv_cnt), 32'd1);
        chk("t1_drain", 32'(out_valid), 32'd0);

        // Single request from requester 1, gray->binary mode
        req1_valid = 1'b1; req1_data = 4'b1110; req1_mode = 1'b1;
        #1;
        chk("t2_ready1", 32'(req1_ready), 32'd1);
        step;
        req1_valid = 1'b0;
`ifdef GRAY_CONV_ARB_G2B_EN
        chk("t2_data", 32'(out_data), 32'b1011);
`else
        chk("t2_data", 32'(out_data), 32'b1001);
`endif
        chk("t2_id", 32'(out_id), 32'd1);
        step;
        chk("t2_cnt", 32'(conv_cnt), 32'd2);

        // Contention from reset: grants alternate 0,1,0,1
        rst = 1'b1; step; rst = 1'b0;
        chk("t3_cnt_rst", 32'(conv_cnt), 32'd0);
        req0_valid = 1'b1; req0_data = 4'h3; req0_mode = 1'b0;
        req1_valid = 1'b1; req1_data = 4'hC; req1_mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_ready0", 32'(req0_ready), 32'((k % 2) == 0));
            chk("t3_ready1", 32'(req1_ready), 32'((k % 2) == 1));
            step;
            chk("t3_valid", 32'(out_valid), 32'd1);
            chk("t3_id", 32'(out_id), 32'(k % 2));
            chk("t3_data", 32'(out_data), ((k % 2) == 0) ? 32'h2 : 32'hA);
            chk("t3_cnt", 32'(conv_cnt), 32'(k));
        end

        // Back-pressure: outputs hold, no grants
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_ready0", 32'(req0_ready), 32'd0);
            chk("t4_ready1", 32'(req1_ready), 32'd0);
            step;
            chk("t4_valid", 32'(out_valid), 32'd1);
            chk("t4_id", 32'(out_id), 32'd1);
            chk("t4_data", 32'(out_data), 32'hA);
            chk("t4_cnt", 32'(conv_cnt), 32'd3);
        end
        out_ready = 1'b1;
        #1;
        chk("t4_resume0", 32'(req0_ready), 32'd1);
        chk("t4_resume1", 32'(req1_ready), 32'd0);
        step;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t4_id_next", 32'(out_id), 32'd0);
        chk("t4_data_next", 32'(out_data), 32'h2);
        chk("t4_cnt_next", 32'(conv_cnt), 32'd4);
        step;
        chk("t4_drain", 32'(out_valid), 32'd0);
        chk("t4_cnt_drain", 32'(conv_cnt), 32'd5);

        // Reset while a result is held; rr must return to 0
        req0_valid = 1'b1; req0_data = 4'h9; req0_mode = 1'b0; out_ready = 1'b0;
        step;
        req0_valid = 1'b0;
        chk("t5_held", 32'(out_data), 32'hD);
        rst = 1'b1;
        step;
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_cnt", 32'(conv_cnt), 32'd0);
        chk("t5_data", 32'(out_data), 32'd0);
        rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("t5_rr0", 32'(req0_ready), 32'd1);
        chk("t5_rr1", 32'(req1_ready), 32'd0);
        step;
        chk("t5_id", 32'(out_id), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step;

        // Exhaustive 4-bit sweep through requester 0, both modes
        for (int v = 0; v < 16; v++) begin
            for (int m = 0; m < 2; m++) begin
                req0_valid = 1'b1; req0_data = 4'(v); req0_mode = 1'(m);
                step;
`ifdef GRAY_CONV_ARB_G2B_EN
                exp_s = (m == 1) ? m_g2b(4'(v)) : m_b2g(4'(v));
`else
                exp_s = m_b2g(4'(v));
`endif
                chk("sweep", 32'(out_data), 32'(exp_s));
            end
`ifdef GRAY_CONV_ARB_G2B_EN
            req0_data = m_b2g(4'(v)); req0_mode = 1'b1;
            step;
            chk("roundtrip", 32'(out_data), 32'(v));
`endif
        end
        req0_valid = 1'b0;
        step;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gray_conv_arb.md
GRAY_CONV_ARB -- requirements
Module: gray_conv_arb

Interface
REQ-001 SHALL have parameter: WIDTH, 4, code width in bits (2..16).
REQ-002 SHALL have parameter: CNT_W, 8, width of the completed-conversion counter.
REQ-003 Ports SHALL be exactly:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_data  in  WIDTH  requester 0 operand.
- req0_mode  in  1  0 = binary->gray, 1 = gray->binary.
- req1_valid / req1_ready / req1_data / req1_mode: same as requester 0, for requester 1.
- out_valid  out  1  result held in output register.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  converted code.
- out_id  out  1  requester that owns out_data.
- conv_cnt  out  CNT_W  completed conversions, wraps.
REQ-004 Clock SHALL be clk; reset SHALL be rst, synchronous and active-high; there SHALL be no other clock or reset.

Function
REQ-005 Block SHALL share one combinational converter between two requesters, with one registered output stage.
REQ-006 Slot SHALL be free when out_valid=0 or out_ready=1 in the same cycle.
REQ-007 Grant SHALL occur only when the slot is free; at most one grant per cycle.
REQ-008 Only one requester valid: that requester SHALL be granted.
REQ-009 Both valid: the requester selected by a 1-bit round-robin pointer rr SHALL be granted; the other requester's ready SHALL be 0.
REQ-010 After each grant, rr SHALL point to the non-granted requester; without a grant, rr SHALL hold.
REQ-011 reqN_ready SHALL equal grantN, combinationally from valid, rr, out_valid and out_ready; ready SHALL never be 1 while its valid is 0.
REQ-012 On grant, the next edge SHALL load out_data=convert(data, mode), out_id=granted index and out_valid=1; latency is 1 cycle.
REQ-013 Binary->gray: g[W-1]=b[W-1]; g[i]=b[i+1]^b[i].
REQ-014 Gray->binary: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
REQ-015 With out_valid=1 and out_ready=0, out_data, out_id and out_valid SHALL hold stable.
REQ-016 Drain with no grant (out_valid=1, out_ready=1): out_valid SHALL go to 0 next cycle.
REQ-017 Simultaneous drain and grant SHALL replace the result back-to-back with no bubble; full throughput is 1 result per cycle.
REQ-018 conv_cnt SHALL increment by 1 on each out_valid&&out_ready handshake and wrap from all-ones to 0.
REQ-019 A requester held off for one cycle by contention SHALL be granted on the next free slot; worst-case wait SHALL be 1 grant.

Reset
REQ-020 While rst=1: out_valid=0, out_data=0, out_id=0, conv_cnt=0, rr=0, and req0_ready=req1_ready=0.
REQ-021 Reset mid-transfer SHALL discard the held result with no handshake counted; the first grant after reset SHALL be decided by rr=0.

Configuration
REQ-022 Macro GRAY_CONV_ARB_G2B_EN defined: reqN_mode selects the conversion per REQ-013/014.
REQ-023 Macro GRAY_CONV_ARB_G2B_EN undefined: reqN_mode SHALL be ignored, every request SHALL be converted binary->gray, and no gray->binary logic SHALL be synthesised.

Structure
REQ-024 Package gray_pkg SHALL hold: the WIDTH default constant, the mode encoding (MODE_B2G=0, MODE_G2B=1) and the requester-id type.
REQ-025 Converter SHALL be sub-module gray_conv: combinational, parameter WIDTH, ports data, mode, result, with a generate loop per bit.
REQ-026 Arbiter, output register and counter SHALL live in gray_conv_arb.

Verification
REQ-027 Reset, then req0: data=4'b0101, mode=0, out_ready=1 -> next cycle out_valid=1, out_data=4'b0111, out_id=0, conv_cnt=1 after handshake.
REQ-028 Macro defined, req1: data=4'b1110, mode=1 -> out_data=4'b1011, out_id=1; macro undefined, same stimulus -> out_data=4'b1001.
REQ-029 Both valid every cycle, out_ready=1, from reset -> grants 0,1,0,1; out_id alternates; one result per cycle.
REQ-030 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, req0_ready=req1_ready=0, conv_cnt unchanged.
REQ-031 Exhaustive WIDTH=4 sweep, 16 values, both modes -> matches REQ-013/014; round-trip b2g then g2b returns the input.
REQ-032 rst asserted while out_valid=1 -> next cycle out_valid=0, conv_cnt=0, rr=0.
